// File: rtl/mult_div_unit_pkg.sv
// Shared opcode encodings and state type for the iterative multiply/divide unit.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } md_state_e;

    localparam logic [4:0] MD_LAST_ITER = 5'd31;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface mult_div_unit_if;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_op_x;
    logic [31:0] md_op_y;
    logic        md_busy;
    logic        md_done;
    logic        md_div_zero;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    modport master (
        output md_start, md_op, md_op_x, md_op_y,
        input  md_busy, md_done, md_div_zero, md_hi, md_lo
    );

    modport slave (
        input  md_start, md_op, md_op_x, md_op_y,
        output md_busy, md_done, md_div_zero, md_hi, md_lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO; 32 iterations then a sign-fix cycle.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mult_div_unit_if.slave md
);

    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_r_q, neg_r_d;
    logic        dz_q, dz_d;
    logic        is_div_q, is_div_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        div_zero_q, div_zero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        sgn;
    logic [31:0] ax, ay;
    logic [32:0] sum;
    logic        ge;
    logic [31:0] diff;
    logic [63:0] prod;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        neg_a_d    = neg_a_q;
        neg_r_d    = neg_r_q;
        dz_d       = dz_q;
        is_div_d   = is_div_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        sgn        = (md.md_op == MD_MULT) || (md.md_op == MD_DIV);
        ax         = abs32(md.md_op_x, sgn);
        ay         = abs32(md.md_op_y, sgn);
        sum        = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        ge         = (acc_q[63:31] >= {1'b0, opnd_q});
        diff       = acc_q[62:31] - opnd_q;
        prod       = neg_a_q ? (~acc_q + 64'd1) : acc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (md.md_start) begin
                    case (md.md_op)
                        MD_MULT, MD_MULTU: begin
                            opnd_d   = ax;
                            acc_d    = {32'd0, ay};
                            neg_a_d  = sgn && (md.md_op_x[31] ^ md.md_op_y[31]);
                            neg_r_d  = 1'b0;
                            dz_d     = 1'b0;
                            is_div_d = 1'b0;
                            cnt_d    = MD_LAST_ITER;
                            busy_d   = 1'b1;
                            state_d  = ST_MUL;
                        end
                        MD_DIV, MD_DIVU: begin
                            opnd_d   = ay;
                            acc_d    = {32'd0, ax};
                            neg_a_d  = sgn && (md.md_op_x[31] ^ md.md_op_y[31]);
                            neg_r_d  = sgn && md.md_op_x[31];
                            dz_d     = (md.md_op_y == 32'd0);
                            is_div_d = 1'b1;
                            cnt_d    = MD_LAST_ITER;
                            busy_d   = 1'b1;
                            state_d  = ST_DIV;
                        end
                        MD_MTHI: hi_d = md.md_op_x;
                        MD_MTLO: lo_d = md.md_op_x;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                // {partial product, remaining multiplier bits} shift right together
                acc_d = {sum, acc_q[31:1]};
                cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = ST_FIX;
            end
            ST_DIV: begin
                // restoring step: remainder in [63:32], quotient bits shift into [31:0]
                acc_d = ge ? {diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
                cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (is_div_q) begin
                    // a zero divisor leaves |dividend| as remainder; re-signing it restores the dividend
                    lo_d = dz_q ? '1 : (neg_a_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
                    hi_d = neg_r_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
                    div_zero_d = dz_q;
                end else begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            neg_a_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            dz_q       <= 1'b0;
            is_div_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            neg_a_q    <= neg_a_d;
            neg_r_q    <= neg_r_d;
            dz_q       <= dz_d;
            is_div_q   <= is_div_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign md.md_busy     = busy_q;
    assign md.md_done     = done_q;
    assign md.md_div_zero = div_zero_q;
    assign md.md_hi       = hi_q;
    assign md.md_lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against a native-arithmetic reference model.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_div_unit_if md_if();

    mult_div_unit dut (
        .clk (clk),
        .rst (rst),
        .md  (md_if)
    );

    exp_t        sb_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    bit          allow_overlap = 1'b0;
    logic [31:0] prev_hi, prev_lo;

    always @(posedge clk) begin
        if (!rst && md_if.md_start && md_if.md_busy) begin
            assert (allow_overlap) else begin
                n_err++;
                $error("FAIL protocol: observed start while busy, expected none");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        int          sx, sy;
        longint      p;
        logic [63:0] pu;
        e  = '0;
        sx = x;
        sy = y;
        case (op)
            MD_MULT: begin
                p = longint'(sx) * longint'(sy);
                {e.hi, e.lo} = p;
            end
            MD_MULTU: begin
                pu = {32'd0, x} * {32'd0, y};
                {e.hi, e.lo} = pu;
            end
            MD_DIV: begin
                if (y == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = x; e.dz = 1'b1;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = 32'd0;
                end else begin
                    e.lo = sx / sy; e.hi = sx % sy;
                end
            end
            MD_DIVU: begin
                if (y == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = x; e.dz = 1'b1;
                end else begin
                    e.lo = x / y; e.hi = x % y;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        sb_q.push_back(model(op, x, y));
        prev_hi = md_if.md_hi;
        prev_lo = md_if.md_lo;
        md_if.md_start = 1'b1;
        md_if.md_op    = op;
        md_if.md_op_x  = x;
        md_if.md_op_y  = y;
        @(negedge clk);
        md_if.md_start = 1'b0;
        chk1("busy_rise", md_if.md_busy, 1'b1);
        chk1("done_low", md_if.md_done, 1'b0);
    endtask

    task automatic run_to_done(input string tag, input int unsigned pre);
        int unsigned k;
        bit          held;
        bit          busy_ok;
        exp_t        e;
        k       = pre;
        held    = 1'b1;
        busy_ok = 1'b1;
        while (md_if.md_done !== 1'b1 && k < 200) begin
            if (md_if.md_hi !== prev_hi || md_if.md_lo !== prev_lo) held = 1'b0;
            if (md_if.md_busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        chk({tag, ":latency"}, k, 32'd33);
        chk1({tag, ":busy_held"}, busy_ok, 1'b1);
        chk1({tag, ":hilo_held"}, held, 1'b1);
        chk1({tag, ":busy_fall"}, md_if.md_busy, 1'b0);
        chk({tag, ":sb_size"}, sb_q.size(), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, ":hi"}, md_if.md_hi, e.hi);
            chk({tag, ":lo"}, md_if.md_lo, e.lo);
            chk1({tag, ":div_zero"}, md_if.md_div_zero, e.dz);
        end
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] rx, ry;

        md_if.md_start = 1'b0;
        md_if.md_op    = 3'd0;
        md_if.md_op_x  = 32'd0;
        md_if.md_op_y  = 32'd0;

        repeat (2) @(negedge clk);
        chk1("rst_busy", md_if.md_busy, 1'b0);
        chk1("rst_done", md_if.md_done, 1'b0);
        chk1("rst_dz", md_if.md_div_zero, 1'b0);
        chk("rst_hi", md_if.md_hi, 32'd0);
        chk("rst_lo", md_if.md_lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);        run_to_done("mult", 0);
        issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3);       run_to_done("multu", 0);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);         run_to_done("div_neg", 0);
        issue(MD_DIVU, 32'd100, 32'd7);              run_to_done("divu", 0);
        issue(MD_DIVU, 32'h1234, 32'd0);             run_to_done("divu_zero", 0);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF); run_to_done("div_ovf", 0);
        issue(MD_DIV, 32'hFFFF_FF00, 32'd0);         run_to_done("div_zero_neg", 0);
        @(negedge clk);
        chk1("done_pulse", md_if.md_done, 1'b0);
        chk1("dz_pulse", md_if.md_div_zero, 1'b0);

        md_if.md_start = 1'b1; md_if.md_op = MD_MTHI; md_if.md_op_x = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mthi_hi", md_if.md_hi, 32'hDEAD_BEEF);
        chk1("mthi_busy", md_if.md_busy, 1'b0);
        md_if.md_op = MD_MTLO; md_if.md_op_x = 32'h0BAD_F00D;
        @(negedge clk);
        md_if.md_start = 1'b0;
        chk("mtlo_lo", md_if.md_lo, 32'h0BAD_F00D);
        chk("mtlo_hi", md_if.md_hi, 32'hDEAD_BEEF);
        chk1("mtlo_busy", md_if.md_busy, 1'b0);
        chk1("mtlo_done", md_if.md_done, 1'b0);

        md_if.md_start = 1'b1; md_if.md_op = 3'd7; md_if.md_op_x = 32'h1111_1111;
        @(negedge clk);
        md_if.md_start = 1'b0;
        @(negedge clk);
        chk1("unk_busy", md_if.md_busy, 1'b0);
        chk("unk_hi", md_if.md_hi, 32'hDEAD_BEEF);
        chk("unk_lo", md_if.md_lo, 32'h0BAD_F00D);

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        repeat (4) @(negedge clk);
        allow_overlap = 1'b1;
        md_if.md_start = 1'b1; md_if.md_op = MD_MULT; md_if.md_op_x = 32'd7; md_if.md_op_y = 32'd9;
        @(negedge clk);
        md_if.md_start = 1'b0;
        allow_overlap = 1'b0;
        run_to_done("overlap", 5);

        md_if.md_start = 1'b1; md_if.md_op = MD_DIV; md_if.md_op_x = 32'd1000; md_if.md_op_y = 32'd3;
        @(negedge clk);
        md_if.md_start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk1("abort_busy", md_if.md_busy, 1'b0);
        chk1("abort_done", md_if.md_done, 1'b0);
        chk1("abort_dz", md_if.md_div_zero, 1'b0);
        chk("abort_hi", md_if.md_hi, 32'd0);
        chk("abort_lo", md_if.md_lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk1("post_rst_busy", md_if.md_busy, 1'b0);
        issue(MD_MULT, 32'd5, 32'd6);                run_to_done("mult_5x6", 0);

        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 3));
            rx  = $urandom;
            ry  = $urandom;
            if (i % 4 == 3) ry = 32'd0;
            if (i == 5) ry = 32'($urandom_range(1, 15));
            if (i == 6) ry = 32'hFFFF_FFFF;
            issue(rop, rx, ry);
            run_to_done("random", 0);
        end
        @(negedge clk);
        chk1("final_done", md_if.md_done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
